// File: rtl/sipo_load_ctrl_pkg.sv
// rtl/sipo_load_ctrl_pkg.sv - shared types and width helpers for the SIPO load sequencer
//
// Purpose: FSM state encoding, default row depth and the word-counter
// width helper used by sipo_load_ctrl and sipo_lat_pipe.
// Ports: none (package).
package sipo_load_ctrl_pkg;

  // Default words per row; matches the SIPO depth.
  localparam int KERNEL_WIDTH = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_REFRESH = 3'd3,
    ST_FLUSH   = 3'd4
  } state_e;

  // Ceiling log2, C_LOG_2(1) = 0.
  function automatic int c_log_2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) begin
      w = w + 1;
    end
    return w;
  endfunction

  // Word counter needs at least one bit even for a single-word row.
  function automatic int cnt_width(input int n);
    return (n > 1) ? c_log_2(n) : 1;
  endfunction

endpackage

// File: rtl/sipo_lat_pipe.sv
// rtl/sipo_lat_pipe.sv - read-latency delay line for first/last read flags
//
// Purpose: delays the first-read and last-read markers by DEPTH cycles so
// they line up with the buffer data bus. first_out drives the SIPO begin
// strobe; last_out tells the sequencer the final word has been shifted in.
// Ports:
//   clk       in   clock
//   reset     in   asynchronous reset, active-low
//   first_in  in   word 0 of a row is being read this cycle
//   last_in   in   last word of a row is being read this cycle
//   first_out out  word 0 is on the buffer data bus this cycle
//   last_out  out  last word is on the buffer data bus this cycle
module sipo_lat_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic first_in,
  input  logic last_in,
  output logic first_out,
  output logic last_out
);

  logic [DEPTH-1:0] first_q;
  logic [DEPTH-1:0] first_d;
  logic [DEPTH-1:0] last_q;
  logic [DEPTH-1:0] last_d;

  always_comb begin
    first_d    = first_q;
    last_d     = last_q;
    first_d[0] = first_in;
    last_d[0]  = last_in;
    for (int i = 1; i < DEPTH; i++) begin
      first_d[i] = first_q[i-1];
      last_d[i]  = last_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      first_q <= '0;
      last_q  <= '0;
    end else begin
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

  assign first_out = first_q[DEPTH-1];
  assign last_out  = last_q[DEPTH-1];

endmodule

// File: rtl/sipo_load_ctrl.sv
// rtl/sipo_load_ctrl.sv - sequencer feeding one sipo_bar from a single-port buffer
//
// Purpose: for each of cfg_rows rows, issues NUM consecutive buffer reads,
// pulses the SIPO begin strobe aligned with word 0 on the data bus, refreshes
// the SIPO parallel output once the shadow register is full, and offers the
// row downstream through a valid/ready handshake. Fetch of the next row
// overlaps the consumer holding the current row; only the refresh stalls.
// Optional build macro: SIPO_LOAD_CTRL_PERF_EN adds stall_cnt, a saturating
// count of REFRESH cycles blocked by the consumer.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   start                      one-cycle job command (sampled in IDLE only)
//   cfg_base_addr              address of word 0 of row 0
//   cfg_row_stride             address increment between row starts
//   cfg_rows                   number of rows to load
//   busy, done                 job status; done is a one-cycle pulse
//   buf_rd_en, buf_rd_addr     buffer read port
//   sipo_begin, sipo_refresh   sipo_bar begin_serial_in / refresh_parallel_array
//   row_valid, row_ready       row handshake with the PE array
//   stall_cnt                  (SIPO_LOAD_CTRL_PERF_EN only) blocked-refresh cycles
module sipo_load_ctrl
  import sipo_load_ctrl_pkg::*;
#(
  parameter int NUM    = KERNEL_WIDTH,
  parameter int ADDR_W = 12,
  parameter int ROW_W  = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [ADDR_W-1:0] cfg_row_stride,
  input  logic [ROW_W-1:0]  cfg_rows,
  output logic              busy,
  output logic              done,
  output logic              buf_rd_en,
  output logic [ADDR_W-1:0] buf_rd_addr,
  output logic              sipo_begin,
  output logic              sipo_refresh,
  output logic              row_valid,
  input  logic              row_ready
`ifdef SIPO_LOAD_CTRL_PERF_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int                WCNT_W    = cnt_width(NUM);
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(NUM - 1);

  state_e              state_q,     state_d;
  logic [WCNT_W-1:0]   word_cnt_q,  word_cnt_d;
  logic [ROW_W-1:0]    row_cnt_q,   row_cnt_d;
  logic [ROW_W-1:0]    rows_q,      rows_d;
  logic [ADDR_W-1:0]   row_addr_q,  row_addr_d;
  logic [ADDR_W-1:0]   stride_q,    stride_d;
  logic                done_q,      done_d;
  logic                row_valid_q, row_valid_d;

  logic                rd_en;
  logic [ADDR_W-1:0]   rd_addr;
  logic                first_rd;
  logic                last_rd;
  logic                first_dly;
  logic                last_dly;
  logic                refresh_fire;

  sipo_lat_pipe #(
    .DEPTH (RD_LAT)
  ) u_lat_pipe (
    .clk       (clk),
    .reset     (reset),
    .first_in  (first_rd),
    .last_in   (last_rd),
    .first_out (first_dly),
    .last_out  (last_dly)
  );

  always_comb begin
    state_d      = state_q;
    word_cnt_d   = word_cnt_q;
    row_cnt_d    = row_cnt_q;
    rows_d       = rows_q;
    row_addr_d   = row_addr_q;
    stride_d     = stride_q;
    done_d       = 1'b0;
    rd_en        = 1'b0;
    rd_addr      = '0;
    first_rd     = 1'b0;
    last_rd      = 1'b0;
    refresh_fire = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          // Config is captured here so mid-job changes have no effect.
          rows_d     = cfg_rows;
          stride_d   = cfg_row_stride;
          row_addr_d = cfg_base_addr;
          row_cnt_d  = '0;
          word_cnt_d = '0;
          if (cfg_rows == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end

      ST_FETCH: begin
        rd_en    = 1'b1;
        // Address wraps modulo 2^ADDR_W.
        rd_addr  = row_addr_q + ADDR_W'(word_cnt_q);
        first_rd = (word_cnt_q == '0);
        last_rd  = (word_cnt_q == LAST_WORD);
        if (word_cnt_q == LAST_WORD) begin
          word_cnt_d = '0;
          state_d    = ST_DRAIN;
        end else begin
          word_cnt_d = word_cnt_q + WCNT_W'(1);
        end
      end

      ST_DRAIN: begin
        // The last word reaches the SIPO RD_LAT cycles after its read.
        if (last_dly) begin
          state_d = ST_REFRESH;
        end
      end

      ST_REFRESH: begin
        // Only overwrite the parallel output once the previous row is gone
        // or being consumed this very cycle.
        if (!row_valid_q || row_ready) begin
          refresh_fire = 1'b1;
          if (row_cnt_q == rows_q - ROW_W'(1)) begin
            state_d = ST_FLUSH;
          end else begin
            row_cnt_d  = row_cnt_q + ROW_W'(1);
            row_addr_d = row_addr_q + stride_q;
            state_d    = ST_FETCH;
          end
        end
      end

      ST_FLUSH: begin
        if (row_valid_q && row_ready) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // A refresh in the same cycle as a handshake keeps row_valid high: the
  // new row replaces the one just consumed.
  always_comb begin
    row_valid_d = row_valid_q;
    if (refresh_fire) begin
      row_valid_d = 1'b1;
    end else if (row_valid_q && row_ready) begin
      row_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      word_cnt_q  <= '0;
      row_cnt_q   <= '0;
      rows_q      <= '0;
      row_addr_q  <= '0;
      stride_q    <= '0;
      done_q      <= 1'b0;
      row_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      row_cnt_q   <= row_cnt_d;
      rows_q      <= rows_d;
      row_addr_q  <= row_addr_d;
      stride_q    <= stride_d;
      done_q      <= done_d;
      row_valid_q <= row_valid_d;
    end
  end

`ifdef SIPO_LOAD_CTRL_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == ST_IDLE && start) begin
      stall_cnt_d = '0;
    end else if (state_q == ST_REFRESH && row_valid_q && !row_ready &&
                 stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

  assign busy         = (state_q != ST_IDLE);
  assign done         = done_q;
  assign buf_rd_en    = rd_en;
  assign buf_rd_addr  = rd_addr;
  assign sipo_begin   = first_dly;
  assign sipo_refresh = refresh_fire;
  assign row_valid    = row_valid_q;

endmodule

// File: doc/sipo_load_ctrl.md
Name: sipo_load_ctrl

Overview:
- Sequencer that feeds one sipo_bar instance from a single-port on-chip buffer. Used for both activation and weight paths.
- Issues NUM consecutive buffer reads per row and pulses the SIPO begin strobe aligned to the returned data. Refreshes the SIPO parallel output once the shadow register is full.
- Hands each assembled row to the downstream PE array through a valid/ready handshake. Steps through cfg_rows rows at a programmable address stride.

Parameters:
- NUM, 3, words per row; equals the SIPO depth (KERNEL_WIDTH).
- ADDR_W, 12, buffer address width.
- ROW_W, 8, width of the row counter and cfg_rows.
- RD_LAT, 1, buffer read latency in cycles (>=1).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-low
- start  in  1  one-cycle command pulse, sampled in IDLE only
- cfg_base_addr  in  ADDR_W  address of word 0 of row 0
- cfg_row_stride  in  ADDR_W  address increment between row starts
- cfg_rows  in  ROW_W  number of rows to load
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the job completes
- buf_rd_en  out  1  buffer read strobe
- buf_rd_addr  out  ADDR_W  buffer read address
- sipo_begin  out  1  drives sipo_bar begin_serial_in
- sipo_refresh  out  1  drives sipo_bar refresh_parallel_array
- row_valid  out  1  sipo parallel_array holds an unconsumed row
- row_ready  in  1  consumer accepts the row

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0. Reset is asynchronous and takes effect immediately, including mid-job. An in-flight row is discarded.
- Config is latched when start is accepted. Config changes mid-job are ignored. start while busy is ignored.
- States:
  - IDLE: on start with cfg_rows!=0, go to FETCH with row_cnt=0, row_addr=base. On start with cfg_rows==0, pulse done in the next cycle; no reads issued, busy stays 0.
  - FETCH: buf_rd_en=1 for exactly NUM consecutive cycles. buf_rd_addr=row_addr+word_cnt (modulo 2^ADDR_W, wraps silently). Then go to DRAIN.
  - DRAIN: wait until the last word has been shifted into the SIPO, i.e. RD_LAT cycles after the last read. Then go to REFRESH.
  - REFRESH: assert sipo_refresh for one cycle when (!row_valid || row_ready), else hold.
    - If more rows remain: row_cnt++, row_addr+=stride, go to FETCH next cycle.
    - On the last row: go to FLUSH.
  - FLUSH: wait for the final row's handshake (row_valid && row_ready). Then pulse done, drop busy the same cycle, and return to IDLE.
- sipo_begin: first-word read delayed by RD_LAT, one cycle wide. Coincides with word 0 on the buffer data bus. Never asserted while a SIPO shift is in progress.
- Earliest refresh is FETCH_start+RD_LAT+NUM. The next FETCH never starts before the refresh, so the shadow register is never overwritten unconsumed.
- row_valid handshake:
  - Set the cycle after sipo_refresh.
  - Cleared the cycle after row_valid && row_ready, unless a refresh occurs the same cycle; then it stays 1 (new row replaces the consumed row).
- Fetch of row k+1 overlaps the consumer holding row k. Only the refresh stalls.

Optional Feature:
- Macro SIPO_LOAD_CTRL_PERF_EN.
- Defined:
  - Adds output stall_cnt (16 bits, saturating). It counts cycles spent in REFRESH blocked by the consumer.
  - Cleared on an accepted start; held after done.
- Undefined: the port and the counter are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package/header (def_params.vh):
  - FSM state encodings (IDLE, FETCH, DRAIN, REFRESH, FLUSH).
  - Widths: C_LOG_2-derived word-counter width, and a default NUM tied to KERNEL_WIDTH.
- One natural sub-module, sipo_lat_pipe: an RD_LAT-deep shift pipe carrying the first-read and last-read flags to generate sipo_begin and the DRAIN exit.

Test Plan:
All scenarios use NUM=3 and RD_LAT=1; start is pulsed in cycle 0.
- Single row: base=0x010, rows=1, row_ready=1 → rd_en cycles 1-3, addr 0x010/0x011/0x012; sipo_begin cycle 2; sipo_refresh cycle 5; row_valid cycle 6; done cycle 7.
- Multi-row: base=0x010, stride=0x020, rows=3, row_ready=1 → reads at 0x010-012, 0x030-032, 0x050-052; refresh at cycles 5, 10, 15; exactly 3 refresh pulses; one done pulse.
- Backpressure: rows=2, row_ready=0 until cycle 20 → second fetch still cycles 6-8; refresh held from cycle 10 until cycle 20; row_valid stays 1 throughout; done only after the second row is accepted.
- Zero rows: cfg_rows=0 → done cycle 1; no rd_en, sipo_begin or refresh; busy never 1.
- Reset mid-FETCH: reset low at cycle 2 → all outputs 0 immediately. After release, a new start with base=0x100 reads from 0x100.
- Start-while-busy and address wrap: a second start in cycle 3 is ignored. Then base=0xFFF, rows=1 reads 0xFFF, 0x000, 0x001. With PERF_EN, stall_cnt equals the blocked-cycle count from the backpressure scenario (10).
